// File: rtl/video_sof_gate_if.sv
// AXI4-Stream video interface (tdata, tuser = start of frame, tlast = end of line)
// shared by the input and output sides of video_sof_gate.
interface axi4_stream_if #(
    parameter int unsigned TDATA_WIDTH = 16
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tuser;
    logic                   tlast;

    modport master (
        output tvalid,
        output tdata,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tuser,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/video_sof_gate.sv
// Frame-lock and line-length conditioner for a raw camera stream: every output line is
// exactly FRAME_RES_X beats. Define VIDEO_SOF_GATE_PAD_EN to zero-pad short lines.
module video_sof_gate #(
    parameter int unsigned FRAME_RES_X = 1920,
    parameter int unsigned TDATA_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    axi4_stream_if.slave         video_i,
    axi4_stream_if.master        video_o,
    output logic                 lock_o,
    output logic [31:0]          frame_cnt_o,
    output logic [15:0]          trunc_cnt_o,
    output logic [15:0]          short_cnt_o
);

    localparam int unsigned XW     = (FRAME_RES_X > 1) ? $clog2(FRAME_RES_X) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_RES_X - 1);
    localparam logic [15:0]   SAT16  = 16'hFFFF;

`ifdef VIDEO_SOF_GATE_PAD_EN
    typedef enum logic [1:0] {WAIT_SOF = 2'd0, PASS = 2'd1, DROP = 2'd2, PAD = 2'd3} state_e;
`else
    typedef enum logic [1:0] {WAIT_SOF = 2'd0, PASS = 2'd1, DROP = 2'd2} state_e;
`endif

    state_e                 state_q, state_d;
    logic [XW-1:0]          x_q, x_d;
    logic                   vld_q;
    logic [TDATA_WIDTH-1:0] data_q;
    logic                   user_q;
    logic                   last_q;
    logic                   lock_q;
    logic [31:0]            frame_q;
    logic [15:0]            trunc_q;
    logic [15:0]            short_q;

    logic                   ld_en_c;
    logic                   in_ready_c;
    logic                   in_valid_c;
    logic                   load_c;
    logic [TDATA_WIDTH-1:0] ld_data_c;
    logic                   ld_user_c;
    logic                   ld_last_c;
    logic                   trunc_inc_c;
    logic                   short_inc_c;
    logic                   lock_set_c;
    logic [XW-1:0]          x_inc_c;

    assign ld_en_c    = !vld_q || video_o.tready;
    assign in_valid_c = video_i.tvalid && ld_en_c;
    assign x_inc_c    = XW'(x_q + XW'(1));

    // Next state, input acceptance and output-stage load selection
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        in_ready_c  = ld_en_c;
        load_c      = 1'b0;
        ld_data_c   = video_i.tdata;
        ld_user_c   = 1'b0;
        ld_last_c   = 1'b0;
        trunc_inc_c = 1'b0;
        short_inc_c = 1'b0;
        lock_set_c  = 1'b0;

        case (state_q)
            WAIT_SOF, DROP: begin
                if (in_valid_c && video_i.tuser) begin
                    load_c     = 1'b1;
                    ld_user_c  = 1'b1;
                    x_d        = XW'(1);
                    lock_set_c = 1'b1;
                    state_d    = PASS;
                end else if (in_valid_c && video_i.tlast && (state_q == DROP)) begin
                    x_d     = '0;
                    state_d = PASS;
                end
            end

            PASS: begin
                if (in_valid_c) begin
                    if ((x_q == X_LAST) && !video_i.tlast) begin
                        // Line too long: close it here and discard the remainder
                        load_c      = 1'b1;
                        ld_last_c   = 1'b1;
                        trunc_inc_c = 1'b1;
                        x_d         = '0;
                        state_d     = DROP;
                    end else if ((x_q != '0) && video_i.tuser) begin
                        short_inc_c = 1'b1;
`ifdef VIDEO_SOF_GATE_PAD_EN
                        in_ready_c  = 1'b0;
                        state_d     = PAD;
`else
                        load_c      = 1'b1;
                        ld_user_c   = 1'b1;
                        x_d         = XW'(1);
`endif
                    end else if (video_i.tlast && (x_q != X_LAST)) begin
                        short_inc_c = 1'b1;
                        load_c      = 1'b1;
`ifdef VIDEO_SOF_GATE_PAD_EN
                        ld_user_c   = (x_q == '0) && video_i.tuser;
                        x_d         = x_inc_c;
                        state_d     = PAD;
`else
                        ld_user_c   = (x_q == '0) && video_i.tuser;
                        ld_last_c   = 1'b1;
                        x_d         = '0;
`endif
                    end else begin
                        load_c    = 1'b1;
                        ld_user_c = (x_q == '0) && video_i.tuser;
                        ld_last_c = (x_q == X_LAST);
                        x_d       = (x_q == X_LAST) ? '0 : x_inc_c;
                    end
                end
            end

`ifdef VIDEO_SOF_GATE_PAD_EN
            PAD: begin
                in_ready_c = 1'b0;
                if (ld_en_c) begin
                    load_c    = 1'b1;
                    ld_data_c = '0;
                    ld_last_c = (x_q == X_LAST);
                    x_d       = (x_q == X_LAST) ? '0 : x_inc_c;
                    if (x_q == X_LAST) state_d = PASS;
                end
            end
`endif

            default: begin
                x_d     = '0;
                state_d = WAIT_SOF;
            end
        endcase

        if (rst_i) in_ready_c = 1'b0;
    end

    // State, output stage and status registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WAIT_SOF;
            x_q     <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
            lock_q  <= 1'b0;
            frame_q <= '0;
            trunc_q <= '0;
            short_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            if (ld_en_c) begin
                vld_q <= load_c;
                if (load_c) begin
                    data_q <= ld_data_c;
                    user_q <= ld_user_c;
                    last_q <= ld_last_c;
                end
            end
            if (lock_set_c) lock_q <= 1'b1;
            if (vld_q && video_o.tready && user_q) frame_q <= frame_q + 32'd1;
            if (trunc_inc_c && (trunc_q != SAT16)) trunc_q <= trunc_q + 16'd1;
            if (short_inc_c && (short_q != SAT16)) short_q <= short_q + 16'd1;
        end
    end

    assign video_i.tready = in_ready_c;
    assign video_o.tvalid = vld_q;
    assign video_o.tdata  = data_q;
    assign video_o.tuser  = user_q;
    assign video_o.tlast  = last_q;
    assign lock_o         = lock_q;
    assign frame_cnt_o    = frame_q;
    assign trunc_cnt_o    = trunc_q;
    assign short_cnt_o    = short_q;

endmodule

// File: tb/tb_video_sof_gate.sv
// Directed bench for video_sof_gate with FRAME_RES_X=8; expectations follow
// VIDEO_SOF_GATE_PAD_EN when it is defined.
module tb_video_sof_gate;
    localparam int unsigned RES_X = 8;
    localparam int unsigned DW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_stream_if #(.TDATA_WIDTH(DW)) vin ();
    axi4_stream_if #(.TDATA_WIDTH(DW)) vout ();

    logic        lock;
    logic [31:0] fcnt;
    logic [15:0] tcnt;
    logic [15:0] scnt;

    video_sof_gate #(.FRAME_RES_X(RES_X), .TDATA_WIDTH(DW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .video_i    (vin),
        .video_o    (vout),
        .lock_o     (lock),
        .frame_cnt_o(fcnt),
        .trunc_cnt_o(tcnt),
        .short_cnt_o(scnt)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    beat_t outq[$];
    beat_t expq[$];
    int    errors = 0;
    int    checks = 0;
    int    stall_cnt = 0;
    int    viol_cnt = 0;
    bit    rand_rdy = 1'b0;

    // Output capture on each handshake
    always @(posedge clk)
        if (!rst && vout.tvalid && vout.tready) outq.push_back({vout.tdata, vout.tuser, vout.tlast});

    // Sink ready: constant 1 or random
    always @(negedge clk) vout.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

    // Input stall and unexplained-backpressure counters, mid-cycle
    always @(negedge clk) begin
        #2;
        if (!rst && vin.tvalid && !vin.tready) stall_cnt++;
        if (!rst && !vin.tready && !(vout.tvalid && !vout.tready)) viol_cnt++;
    end

    task automatic send(input logic [15:0] d, input logic u, input logic l);
        vin.tdata  = d;
        vin.tuser  = u;
        vin.tlast  = l;
        vin.tvalid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (vin.tready) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: tready=0 for 200 cycles, required 1");
    endtask

    task automatic send_line(input logic [15:0] base, input int n, input logic sof, input logic eol);
        for (int i = 0; i < n; i++) send(16'(base + i), sof && (i == 0), eol && (i == n - 1));
    endtask

    task automatic idle(input int n);
        vin.tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_line(input logic [15:0] base, input int n, input logic sof, input logic eol);
        for (int i = 0; i < n; i++) expq.push_back({16'(base + i), sof && (i == 0), eol && (i == n - 1)});
    endtask

    task automatic wait_out(input int n);
        for (int c = 0; c < 3000 && outq.size() < n; c++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        vin.tvalid = 1'b1; vin.tuser = 1'b1; vin.tlast = 1'b0; vin.tdata = 16'h1234;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (vout.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", vout.tvalid); end
        checks++; if ({vout.tuser, vout.tlast} !== 2'b00) begin errors++; $display("FAIL rst_tuser_tlast: got %b want 00", {vout.tuser, vout.tlast}); end
        checks++; if (vout.tdata !== 16'h0) begin errors++; $display("FAIL rst_tdata: got %h want 0000", vout.tdata); end
        checks++; if (vin.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", vin.tready); end
        checks++; if ({lock, fcnt, tcnt, scnt} !== 65'h0) begin errors++; $display("FAIL rst_status: lock=%b frame=%0d trunc=%0d short=%0d want all 0", lock, fcnt, tcnt, scnt); end
        @(negedge clk);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_sof_lock;
        outq.delete(); expq.delete();
        send_line(16'h0010, 3, 1'b0, 1'b0);
        idle(3);
        checks++; if (lock !== 1'b0 || outq.size() != 0) begin errors++; $display("FAIL sof_predrop: lock=%b beats=%0d want lock=0 beats=0", lock, outq.size()); end
        send(16'h0100, 1'b1, 1'b0);
        #1;
        checks++; if ({vout.tvalid, vout.tuser, vout.tdata} !== {2'b11, 16'h0100}) begin errors++; $display("FAIL sof_latency: v=%b u=%b d=%h want v=1 u=1 d=0100", vout.tvalid, vout.tuser, vout.tdata); end
        for (int i = 1; i < 8; i++) send(16'(16'h0100 + i), 1'b0, i == 7);
        idle(1);
        exp_line(16'h0100, 8, 1'b1, 1'b1);
        wait_out(8);
        checks++; if (outq.size() != expq.size()) begin errors++; $display("FAIL sof_count: got %0d beats want %0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== expq[i]) begin errors++; $display("FAIL sof_beat%0d: got d=%h u=%b l=%b want d=%h u=%b l=%b", i, outq[i].d, outq[i].u, outq[i].l, expq[i].d, expq[i].u, expq[i].l); end
        end
        checks++; if (lock !== 1'b1 || fcnt !== 32'd1) begin errors++; $display("FAIL sof_status: lock=%b frame=%0d want lock=1 frame=1", lock, fcnt); end
    endtask

    task automatic test_truncate;
        outq.delete(); expq.delete();
        send_line(16'h0200, 10, 1'b0, 1'b1);
        send_line(16'h0300, 8, 1'b0, 1'b1);
        idle(1);
        exp_line(16'h0200, 8, 1'b0, 1'b1);
        exp_line(16'h0300, 8, 1'b0, 1'b1);
        wait_out(16);
        checks++; if (outq.size() != expq.size()) begin errors++; $display("FAIL trunc_count: got %0d beats want %0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== expq[i]) begin errors++; $display("FAIL trunc_beat%0d: got d=%h u=%b l=%b want d=%h u=%b l=%b", i, outq[i].d, outq[i].u, outq[i].l, expq[i].d, expq[i].u, expq[i].l); end
        end
        checks++; if (tcnt !== 16'd1 || scnt !== 16'd0) begin errors++; $display("FAIL trunc_status: trunc=%0d short=%0d want 1/0", tcnt, scnt); end
    endtask

    task automatic test_short_line;
        int exp_stall;
        outq.delete(); expq.delete();
        stall_cnt = 0;
        send_line(16'h0400, 5, 1'b0, 1'b1);
        send_line(16'h0500, 8, 1'b0, 1'b1);
        idle(1);
`ifdef VIDEO_SOF_GATE_PAD_EN
        exp_line(16'h0400, 5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) expq.push_back({16'h0000, 1'b0, i == 2});
        exp_stall = 3;
`else
        exp_line(16'h0400, 5, 1'b0, 1'b1);
        exp_stall = 0;
`endif
        exp_line(16'h0500, 8, 1'b0, 1'b1);
        wait_out(expq.size());
        checks++; if (outq.size() != expq.size()) begin errors++; $display("FAIL short_count: got %0d beats want %0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== expq[i]) begin errors++; $display("FAIL short_beat%0d: got d=%h u=%b l=%b want d=%h u=%b l=%b", i, outq[i].d, outq[i].u, outq[i].l, expq[i].d, expq[i].u, expq[i].l); end
        end
        checks++; if (stall_cnt != exp_stall) begin errors++; $display("FAIL short_stall: got %0d cycles want %0d", stall_cnt, exp_stall); end
        checks++; if (scnt !== 16'd1 || tcnt !== 16'd1) begin errors++; $display("FAIL short_status: short=%0d trunc=%0d want 1/1", scnt, tcnt); end
    endtask

    task automatic test_early_sof;
        int exp_stall;
        outq.delete(); expq.delete();
        stall_cnt = 0;
        send_line(16'h0600, 3, 1'b0, 1'b0);
        send_line(16'h0700, 8, 1'b1, 1'b1);
        idle(1);
        exp_line(16'h0600, 3, 1'b0, 1'b0);
`ifdef VIDEO_SOF_GATE_PAD_EN
        for (int i = 0; i < 5; i++) expq.push_back({16'h0000, 1'b0, i == 4});
        exp_stall = 6;
`else
        exp_stall = 0;
`endif
        exp_line(16'h0700, 8, 1'b1, 1'b1);
        wait_out(expq.size());
        checks++; if (outq.size() != expq.size()) begin errors++; $display("FAIL esof_count: got %0d beats want %0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== expq[i]) begin errors++; $display("FAIL esof_beat%0d: got d=%h u=%b l=%b want d=%h u=%b l=%b", i, outq[i].d, outq[i].u, outq[i].l, expq[i].d, expq[i].u, expq[i].l); end
        end
        checks++; if (stall_cnt != exp_stall) begin errors++; $display("FAIL esof_stall: got %0d cycles want %0d", stall_cnt, exp_stall); end
        checks++; if (scnt !== 16'd2 || fcnt !== 32'd2) begin errors++; $display("FAIL esof_status: short=%0d frame=%0d want 2/2", scnt, fcnt); end
    endtask

    task automatic test_back_to_back;
        outq.delete(); expq.delete();
        viol_cnt = 0;
        rand_rdy = 1'b1;
        for (int ln = 0; ln < 100; ln++) begin
            send_line(16'(16'h1000 + ln * 16), 8, (ln % 10) == 0, 1'b1);
            exp_line(16'(16'h1000 + ln * 16), 8, (ln % 10) == 0, 1'b1);
        end
        idle(1);
        rand_rdy = 1'b0;
        wait_out(expq.size());
        checks++; if (outq.size() != expq.size()) begin errors++; $display("FAIL b2b_count: got %0d beats want %0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== expq[i]) begin errors++; $display("FAIL b2b_beat%0d: got d=%h u=%b l=%b want d=%h u=%b l=%b", i, outq[i].d, outq[i].u, outq[i].l, expq[i].d, expq[i].u, expq[i].l); end
        end
        checks++; if (viol_cnt != 0) begin errors++; $display("FAIL b2b_ready: tready low without backpressure %0d cycles want 0", viol_cnt); end
        checks++; if (fcnt !== 32'd12) begin errors++; $display("FAIL b2b_frames: got %0d want 12", fcnt); end
    endtask

    task automatic test_reset_mid;
        outq.delete(); expq.delete();
        send_line(16'h0900, 4, 1'b1, 1'b0);
        vin.tdata = 16'h0904; vin.tuser = 1'b0; vin.tlast = 1'b0; vin.tvalid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if ({vout.tvalid, vout.tuser, vout.tlast, vout.tdata} !== 19'h0) begin errors++; $display("FAIL rmid_out: v=%b u=%b l=%b d=%h want all 0", vout.tvalid, vout.tuser, vout.tlast, vout.tdata); end
        checks++; if ({lock, fcnt, tcnt, scnt, vin.tready} !== 66'h0) begin errors++; $display("FAIL rmid_status: lock=%b frame=%0d trunc=%0d short=%0d rdy=%b want all 0", lock, fcnt, tcnt, scnt, vin.tready); end
        @(negedge clk);
        rst = 1'b0;
        outq.delete();
        send_line(16'h0904, 4, 1'b0, 1'b1);
        send_line(16'h0A00, 8, 1'b1, 1'b1);
        idle(1);
        exp_line(16'h0A00, 8, 1'b1, 1'b1);
        wait_out(8);
        checks++; if (outq.size() != expq.size()) begin errors++; $display("FAIL rmid_count: got %0d beats want %0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== expq[i]) begin errors++; $display("FAIL rmid_beat%0d: got d=%h u=%b l=%b want d=%h u=%b l=%b", i, outq[i].d, outq[i].u, outq[i].l, expq[i].d, expq[i].u, expq[i].l); end
        end
        checks++; if (fcnt !== 32'd1 || lock !== 1'b1) begin errors++; $display("FAIL rmid_frames: frame=%0d lock=%b want 1/1", fcnt, lock); end
    endtask

    initial begin
        vin.tvalid = 1'b0;
        vin.tdata  = '0;
        vin.tuser  = 1'b0;
        vin.tlast  = 1'b0;
        @(negedge clk);
        test_reset();
        test_sof_lock();
        test_truncate();
        test_short_line();
        test_early_sof();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/video_sof_gate.md
VIDEO_SOF_GATE -- requirements
Module: video_sof_gate

Interface
REQ-001 Parameter FRAME_RES_X, default 1920, pixels per line; legal range 2..65535.
REQ-002 Parameter TDATA_WIDTH, default 16, pixel width in bits.
REQ-003 clk_i  input  1  single clock for all logic.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 video_i  axi4_stream_if.slave  TDATA_WIDTH  raw camera stream; tuser = start of frame (SOF), tlast = end of line (EOL).
REQ-006 video_o  axi4_stream_if.master  TDATA_WIDTH  conditioned stream; every line is exactly FRAME_RES_X beats; feeds the frame buffer input.
REQ-007 lock_o  output  1  high once an SOF has been accepted since reset.
REQ-008 frame_cnt_o  output  32  SOF beats sent on video_o; wraps modulo 2^32.
REQ-009 trunc_cnt_o  output  16  long lines truncated; saturates at 0xFFFF.
REQ-010 short_cnt_o  output  16  short lines detected; saturates at 0xFFFF.

Function
REQ-011 Output stage is one register; video_o.tvalid/tdata/tuser/tlast are registered; latency from input to output handshake is 1 cycle.
REQ-012 Stage load enable is !video_o.tvalid || video_o.tready; video_i.tready is 0 whenever load enable is 0.
REQ-013 Pixel counter x counts from 0 to FRAME_RES_X-1; it advances on each beat loaded into the output register; it returns to 0 after a beat with output tlast=1.
REQ-014 FSM states: WAIT_SOF, PASS, DROP, PAD.
REQ-015 WAIT_SOF: video_i.tready=1; beats with tuser=0 are discarded; a beat with tuser=1 is loaded with x=0 and tuser=1; lock_o is set; next state is PASS.
REQ-016 PASS: each input beat is loaded; output tuser = input tuser at x=0, otherwise 0; output tlast=1 exactly at x=FRAME_RES_X-1.
REQ-017 PASS, x=FRAME_RES_X-1, input tlast=0: load the beat with tlast=1; increment trunc_cnt_o; next state is DROP.
REQ-018 DROP: video_i.tready=1; beats are discarded up to and including input tlast; then next state is PASS.
REQ-019 DROP, input tuser=1: the beat is not discarded; it is loaded as x=0 SOF; next state is PASS.
REQ-020 PASS, input tlast=1 at x<FRAME_RES_X-1: short line; increment short_cnt_o; the beat is handled per REQ-031/032.
REQ-021 PASS, input tuser=1 at x>0: short line; increment short_cnt_o; handled per REQ-031/032 with the SOF beat held pending.
REQ-022 frame_cnt_o increments on each video_o handshake with tuser=1.
REQ-023 If a truncation and a short line occur on the same beat, only one counter event is recorded (truncation wins).
REQ-024 Output tdata is never modified; padding beats carry tdata=0 and tuser=0.

Reset
REQ-025 While rst_i=1 on a clk_i edge: state is WAIT_SOF; x=0; video_o.tvalid=0; tuser=0; tlast=0; tdata=0.
REQ-026 Reset values: lock_o=0; all counters=0; video_i.tready=0 during reset.
REQ-027 Reset mid-line discards the partial line; the output register contents are lost; the first output after reset is an SOF beat.

Configuration
REQ-028 The macro VIDEO_SOF_GATE_PAD_EN compiles padding in or out.
REQ-029 Both builds keep the port list identical.
REQ-030 Both builds keep the counter behaviour identical.
REQ-031 With VIDEO_SOF_GATE_PAD_EN, early EOL:
  - load the beat with tlast=0;
  - enter PAD, with video_i.tready=0;
  - emit zero beats until x=FRAME_RES_X-1, that beat carrying tlast=1;
  - then return to PASS.
  Early SOF: enter PAD without consuming the SOF beat; after padding, accept it as x=0 SOF.
REQ-032 Without VIDEO_SOF_GATE_PAD_EN, PAD is absent.
  - Early EOL: forward the beat with tlast=1; set x=0.
  - Early SOF: load the beat as x=0 SOF immediately; the preceding output line is left without tlast.

Verification
REQ-033 FRAME_RES_X=8; 3 non-SOF beats, then SOF plus 7 beats with tlast on the 8th -> first 3 beats dropped; 8 beats out with tuser on beat 0 and tlast on beat 7; frame_cnt_o=1.
REQ-034 A 10-beat line with tlast on the 10th -> 8 beats out with tlast on the 8th; 2 beats dropped; trunc_cnt_o=1.
REQ-035 PAD_EN, a 5-beat line with tlast on the 5th -> 5 data beats plus 3 zero beats; tlast on beat 8; short_cnt_o=1; input stalled 3 cycles.
REQ-036 No PAD_EN, same stimulus -> 5 beats out with tlast on beat 5; short_cnt_o=1.
REQ-037 video_o.tready toggled 1/0 randomly over 100 lines -> no beat lost or duplicated; video_i.tready low only while video_o.tvalid=1 and video_o.tready=0, or in PAD.
REQ-038 rst_i pulsed at x=4 -> all outputs at reset values next cycle; beats dropped until the next SOF.
